spi_master_byte: RTL and testbench



---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync2.sv | 31 +++
 rtl/spi_master_byte.sv | 170 +++++++++++++++++
 tb/tb_spi_master_byte.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte master: frame FSM states and bus constants.
package spi_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int SPI_MIN_CLK_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for a single asynchronous input; clears on synchronous reset.
module spi_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // next values of the two synchronizer stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // synchronizer stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_master_byte.sv
// SPI mode-0 master: one MSB-first 8-bit full-duplex frame per accepted start,
// with a guaranteed SSEL-high gap between frames.
module spi_master_byte
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int GAP     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  output logic                  busy,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  SCK,
  output logic                  SSEL,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP + 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  spi_state_e            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [2:0]            bit_q, bit_d;
  logic [SPI_BYTE_W-1:0] sh_q, sh_d;
  logic                  sck_q, sck_d;
  logic                  ssel_q, ssel_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_s;
  logic                  div_done_s;

  spi_sync2 u_miso_sync (
    .clk (clk),
    .rst (rst),
    .d   (MISO),
    .q   (miso_s)
  );

  assign div_done_s = (div_q == {DIV_W{1'b0}});

  // One shift register serves both directions: tx bits leave from the top
  // while synchronized MISO samples enter at the bottom on each SCK rise.
  // frame sequencing, divider/gap counting and output next-state
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    gap_d      = gap_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    sck_d      = sck_q;
    ssel_d     = ssel_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ssel_d  = 1'b0;
          mosi_d  = tx_data[SPI_BYTE_W-1];
          sh_d    = tx_data;
          busy_d  = 1'b1;
          div_d   = DIV_MAX;
          bit_d   = 3'd0;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP, ST_LOW: begin
        if (div_done_s) begin
          sck_d   = 1'b1;
          sh_d    = {sh_q[SPI_BYTE_W-2:0], miso_s};
          div_d   = DIV_MAX;
          state_d = ST_HIGH;
        end else begin
          div_d = div_q - {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HIGH: begin
        if (div_done_s) begin
          sck_d = 1'b0;
          div_d = DIV_MAX;
          if (bit_q == 3'd7) begin
            state_d = ST_HOLD;
          end else begin
            bit_d   = bit_q + 3'd1;
            mosi_d  = sh_q[SPI_BYTE_W-1];
            state_d = ST_LOW;
          end
        end else begin
          div_d = div_q - {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HOLD: begin
        if (div_done_s) begin
          ssel_d     = 1'b1;
          rx_data_d  = sh_q;
          rx_valid_d = 1'b1;
          gap_d      = {GAP_W{1'b0}};
          state_d    = ST_GAP;
        end else begin
          div_d = div_q - {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          busy_d  = 1'b0;
          gap_d   = {GAP_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + {{(GAP_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        sck_d   = 1'b0;
        ssel_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // state, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= {DIV_W{1'b0}};
      gap_q      <= {GAP_W{1'b0}};
      bit_q      <= 3'd0;
      sh_q       <= {SPI_BYTE_W{1'b0}};
      sck_q      <= 1'b0;
      ssel_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= {SPI_BYTE_W{1'b0}};
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      sck_q      <= sck_d;
      ssel_q     <= ssel_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign SCK      = sck_q;
  assign SSEL     = ssel_q;
  assign MOSI     = mosi_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Bench for spi_master_byte: frame-offset reference model compared every cycle,
// directed boundary cases with literal expectations, then randomized traffic.
module tb_spi_master_byte;

  localparam int D  = 4;
  localparam int G  = 8;
  localparam int FL = 17 * D;

  logic       clk = 1'b0;
  logic       rst, start, MISO;
  logic [7:0] tx_data;
  logic       busy, rx_valid, SCK, SSEL, MOSI;
  logic [7:0] rx_data;

  int total = 0;
  int bad   = 0;

  spi_master_byte #(.CLK_DIV(D), .GAP(G)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .busy     (busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .SCK      (SCK),
    .SSEL     (SSEL),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is described only by its offset k from acceptance.
  // SSEL low for k=1..17D, SCK high in odd D-long phases, rx_valid at k=17D+1,
  // busy through k=17D+GAP. MISO is taken two edges before the sampling cycle.
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_acc = 8'h00;
  logic [7:0] m_rx = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_rx     <= 8'h00;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_tx     <= tx_data;
      end
    end else begin
      if (((m_k + 2) % (2 * D) == D) && ((m_k + 2 - D) / (2 * D) < 8))
        m_acc[7 - (m_k + 2 - D) / (2 * D)] <= MISO;
      if (m_k == FL) m_rx <= m_acc;
      if (m_k == FL + G) m_active <= 1'b0;
      else m_k <= m_k + 1;
    end
  end

  int         miso_mode = 0;
  logic [7:0] sl_byte = 8'h00;
  int         sl_idx = 0;
  int         rises, ssel_low, valid_cnt, ssel_falls, busy_rises;
  int         hrun, brun, gap_run, blow_run;
  logic [7:0] cap;
  logic       prev_sck, prev_ssel, prev_busy;

  task automatic clr_stats();
    rises = 0; ssel_low = 0; valid_cnt = 0; ssel_falls = 0; busy_rises = 0;
    hrun = 0; brun = 0; gap_run = -1; blow_run = -1; cap = 8'h00;
    prev_sck = SCK; prev_ssel = SSEL; prev_busy = busy;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // One clock: compare against the model, update monitors, drive MISO source.
  task automatic tick();
    int         p;
    logic [11:0] got, exp;
    logic       e_mosi;
    bit         mchk;
    @(negedge clk);
    mchk = 1'b0;
    e_mosi = 1'b0;
    if (!m_active) begin
      exp = {1'b1, 1'b0, 1'b0, 1'b0, m_rx};
    end else if (m_k <= FL) begin
      p = (m_k - 1) / D;
      exp = {1'b0, (p % 2 == 1), 1'b1, 1'b0, m_rx};
      mchk = 1'b1;
      e_mosi = m_tx[7 - ((p / 2 > 7) ? 7 : p / 2)];
    end else begin
      exp = {1'b1, 1'b0, 1'b1, (m_k == FL + 1), m_rx};
    end
    got = {SSEL, SCK, busy, rx_valid, rx_data};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL cycle {ssel,sck,busy,valid,rx}: got=%h expected=%h at t=%0t", got, exp, $time);
    end
    if (mchk) begin
      total++;
      if (MOSI !== e_mosi) begin
        bad++;
        $display("FAIL mosi: got=%b expected=%b at t=%0t", MOSI, e_mosi, $time);
      end
    end

    if (SCK && !prev_sck) begin rises++; cap = {cap[6:0], MOSI}; end
    if (!SSEL) ssel_low++;
    if (rx_valid) valid_cnt++;
    if (!SSEL && prev_ssel) begin
      if (ssel_falls == 1) gap_run = hrun;
      ssel_falls++;
    end
    hrun = SSEL ? hrun + 1 : 0;
    if (busy && !prev_busy) begin
      if (busy_rises == 1) blow_run = brun;
      busy_rises++;
    end
    brun = busy ? 0 : brun + 1;

    case (miso_mode)
      0: MISO = 1'b0;
      1: MISO = 1'b1;
      2: begin
        if (!SSEL && prev_ssel) begin
          sl_idx = 7;
          MISO = sl_byte[7];
        end else if (!SSEL && prev_sck && !SCK && sl_idx > 0) begin
          sl_idx--;
          MISO = sl_byte[sl_idx];
        end
      end
      default: begin
        #2;
        MISO = 1'($urandom_range(0, 1));
      end
    endcase
    prev_sck = SCK; prev_ssel = SSEL; prev_busy = busy;
  endtask

  task automatic run_frame(input logic [7:0] tx, output int lat);
    start = 1'b1; tx_data = tx;
    tick();
    start = 1'b0; tx_data = ~tx;
    lat = 1;
    while (!rx_valid && lat < 200) begin tick(); lat++; end
    repeat (G + 2) tick();
  endtask

  int lat, n;

  initial begin
    rst = 1'b1; start = 1'b0; tx_data = 8'h00; MISO = 1'b0;
    repeat (2) @(negedge clk);
    clr_stats();
    tick();
    chk("reset_state", {SCK, SSEL, MOSI, busy, rx_valid, rx_data},
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    rst = 1'b0;
    tick();

    // loopback A5 with tx 3C, plus an ignored start pulse mid-frame
    miso_mode = 2; sl_byte = 8'hA5;
    clr_stats();
    start = 1'b1; tx_data = 8'h3C;
    tick();
    start = 1'b0; tx_data = 8'hFF; lat = 1;
    while (!rx_valid && lat < 200) begin
      start = (lat == 10);
      tick();
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, 69);
    chk("loop_rx", rx_data, 8'hA5);
    chk("sck_rises", rises, 8);
    chk("mosi_bits", cap, 8'h3C);
    chk("ssel_low", ssel_low, 68);
    repeat (G + 10) tick();
    chk("one_frame", ssel_falls, 1);
    chk("one_valid", valid_cnt, 1);

    miso_mode = 0;
    run_frame(8'h81, lat);
    chk("miso0_rx", rx_data, 8'h00);
    miso_mode = 1;
    run_frame(8'h7E, lat);
    chk("miso1_rx", rx_data, 8'hFF);

    // start held high across two frames
    miso_mode = 2; sl_byte = 8'hC3;
    clr_stats();
    start = 1'b1; tx_data = 8'h55; n = 0;
    while (valid_cnt < 2 && n < 400) begin tick(); n++; end
    start = 1'b0;
    chk("held_valids", valid_cnt, 2);
    chk("held_ssel_high", gap_run, G + 1);
    chk("held_busy_low", blow_run, 1);
    chk("held_rx", rx_data, 8'hC3);
    repeat (G + 4) tick();

    // reset after the third SCK rise
    miso_mode = 1;
    run_frame(8'h00, lat);
    miso_mode = 2; sl_byte = 8'h5A;
    clr_stats();
    start = 1'b1; tx_data = 8'h96;
    tick();
    start = 1'b0; n = 0;
    while (rises < 3 && n < 200) begin tick(); n++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out", {SSEL, SCK, busy, MOSI, rx_data}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    repeat (80) tick();
    chk("rst_no_valid", valid_cnt, 0);
    run_frame(8'h0F, lat);
    chk("post_rst_rx", rx_data, 8'h5A);
    chk("post_rst_latency", lat, 69);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int len;
      miso_mode = $urandom_range(0, 3);
      sl_byte = 8'($urandom);
      len = $urandom_range(60, 120);
      for (int c = 0; c < len; c++) begin
        start = ($urandom_range(0, 5) == 0);
        tx_data = 8'($urandom);
        rst = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    rst = 1'b0; start = 1'b0;
    repeat (100) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
